// File: rtl/gt.sv
// gt: registered greater-than comparator for the ALU comparison group.
// Compares register_A against register_B (unsigned, or two's-complement
// when signed_mode=1) and registers the result on a cmp_en edge.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   register_A   left operand (WIDTH bits)
//   register_B   right operand (WIDTH bits)
//   cmp_en       capture enable
//   signed_mode  0 = unsigned compare, 1 = two's-complement compare
//   sign_flag    registered A > B
//   eq_flag      registered A == B
//   lt_flag      registered A < B
//   valid        one-cycle strobe after each capture
module gt #(
    parameter int unsigned WIDTH = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] register_A,
    input  logic [WIDTH-1:0] register_B,
    input  logic             cmp_en,
    input  logic             signed_mode,
    output logic             sign_flag,
    output logic             eq_flag,
    output logic             lt_flag,
    output logic             valid
);

    localparam int unsigned LOW_W = WIDTH - 1;

    logic             msb_a_c;
    logic             msb_b_c;
    logic [LOW_W-1:0] low_a_c;
    logic [LOW_W-1:0] low_b_c;
    logic             low_gt_c;
    logic             gt_c;
    logic             eq_c;
    logic             lt_c;

    // Split operands into sign/magnitude-order bit and the remaining bits.
    assign msb_a_c  = register_A[WIDTH-1];
    assign msb_b_c  = register_B[WIDTH-1];
    assign low_a_c  = register_A[LOW_W-1:0];
    assign low_b_c  = register_B[LOW_W-1:0];
    assign low_gt_c = (low_a_c > low_b_c);

    // When the top bits differ, the operand with MSB set is the larger one
    // unsigned and the smaller one signed; otherwise the low bits decide.
    always_comb begin
        gt_c = 1'b0;
        if (msb_a_c != msb_b_c) begin
            gt_c = signed_mode ? msb_b_c : msb_a_c;
        end else begin
            gt_c = low_gt_c;
        end
    end

    // Equality is bitwise and mode-independent; less-than is the remainder.
    always_comb begin
        eq_c = (register_A == register_B);
        lt_c = ~gt_c & ~eq_c;
    end

    // Result registers: reset wins over capture; flags hold when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_flag <= 1'b0;
            eq_flag   <= 1'b0;
            lt_flag   <= 1'b0;
            valid     <= 1'b0;
        end else if (cmp_en) begin
            sign_flag <= gt_c;
            eq_flag   <= eq_c;
            lt_flag   <= lt_c;
            valid     <= 1'b1;
        end else begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gt.sv
// tb_gt: self-checking bench for gt. A behavioural model built on native
// signed/unsigned relational operators is checked every cycle, and directed
// vectors pin the model with hand-computed flag values.
module tb_gt;

    localparam int unsigned WIDTH = 20;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] register_A;
    logic [WIDTH-1:0] register_B;
    logic             cmp_en;
    logic             signed_mode;
    logic             sign_flag;
    logic             eq_flag;
    logic             lt_flag;
    logic             valid;

    int n_vec = 0;
    int n_bad = 0;

    // Model state
    logic m_gt = 1'b0;
    logic m_eq = 1'b0;
    logic m_lt = 1'b0;
    logic m_valid = 1'b0;
    logic m_captured = 1'b0;
    logic check_en = 1'b0;

    gt #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .register_A  (register_A),
        .register_B  (register_B),
        .cmp_en      (cmp_en),
        .signed_mode (signed_mode),
        .sign_flag   (sign_flag),
        .eq_flag     (eq_flag),
        .lt_flag     (lt_flag),
        .valid       (valid)
    );

    always #5 clk = ~clk;

    // Reference comparisons using the language's own relational operators.
    function automatic logic ref_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s);
        if (s) return ($signed(a) > $signed(b));
        return (a > b);
    endfunction

    function automatic logic ref_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s);
        if (s) return ($signed(a) < $signed(b));
        return (a < b);
    endfunction

    // Model update on the active edge.
    always @(posedge clk) begin
        if (reset) begin
            m_gt       <= 1'b0;
            m_eq       <= 1'b0;
            m_lt       <= 1'b0;
            m_valid    <= 1'b0;
            m_captured <= 1'b0;
        end else if (cmp_en) begin
            m_gt       <= ref_gt(register_A, register_B, signed_mode);
            m_eq       <= (register_A == register_B);
            m_lt       <= ref_lt(register_A, register_B, signed_mode);
            m_valid    <= 1'b1;
            m_captured <= 1'b1;
        end else begin
            m_valid    <= 1'b0;
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            n_vec++;
            if ({sign_flag, eq_flag, lt_flag, valid} !== {m_gt, m_eq, m_lt, m_valid}) begin
                n_bad++;
                $display("FAIL model t=%0t got gt/eq/lt/v=%b%b%b%b expected %b%b%b%b",
                         $time, sign_flag, eq_flag, lt_flag, valid,
                         m_gt, m_eq, m_lt, m_valid);
            end
            if (m_captured) begin
                n_vec++;
                if (!$onehot({sign_flag, eq_flag, lt_flag})) begin
                    n_bad++;
                    $display("FAIL onehot t=%0t got gt/eq/lt=%b%b%b expected exactly one set",
                             $time, sign_flag, eq_flag, lt_flag);
                end
            end
        end
    end

    task automatic expect_lit(input string name, input logic s, input logic e,
                              input logic l, input logic v);
        n_vec++;
        if ({sign_flag, eq_flag, lt_flag, valid} !== {s, e, l, v}) begin
            n_bad++;
            $display("FAIL %s got gt/eq/lt/v=%b%b%b%b expected %b%b%b%b",
                     name, sign_flag, eq_flag, lt_flag, valid, s, e, l, v);
        end
    endtask

    // Called at a negedge: capture on the next edge, check one cycle later.
    task automatic cap_check(input string name, input logic [WIDTH-1:0] a,
                             input logic [WIDTH-1:0] b, input logic m,
                             input logic s, input logic e, input logic l);
        reset       = 1'b0;
        register_A  = a;
        register_B  = b;
        signed_mode = m;
        cmp_en      = 1'b1;
        @(negedge clk);
        expect_lit(name, s, e, l, 1'b1);
        cmp_en = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        cmp_en      = 1'b1;
        register_A  = 20'h12345;
        register_B  = 20'h00001;
        signed_mode = 1'b0;
        @(negedge clk);
        check_en = 1'b1;
        @(negedge clk);
        expect_lit("reset", 1'b0, 1'b0, 1'b0, 1'b0);

        // Unsigned greater, then valid must drop after one idle edge.
        cap_check("ugt", 20'hABCDE, 20'h54321, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        expect_lit("ugt_valid_drop", 1'b1, 1'b0, 1'b0, 1'b0);

        // Unsigned less, then operands swap while idle: flags must hold.
        cap_check("ult", 20'h54321, 20'hABCDE, 1'b0, 1'b0, 1'b0, 1'b1);
        register_A  = 20'hABCDE;
        register_B  = 20'h54321;
        signed_mode = 1'b1;
        repeat (10) @(negedge clk);
        expect_lit("ult_hold", 1'b0, 1'b0, 1'b1, 1'b0);

        // Signed mode and boundaries, back-to-back.
        cap_check("sgn_neg_a",  20'hABCDE, 20'h54321, 1'b1, 1'b0, 1'b0, 1'b1);
        cap_check("sgn_m1_min", 20'hFFFFF, 20'h80000, 1'b1, 1'b1, 1'b0, 1'b0);
        cap_check("uns_ff_80",  20'hFFFFF, 20'h80000, 1'b0, 1'b1, 1'b0, 1'b0);
        cap_check("sgn_max_min",20'h7FFFF, 20'h80000, 1'b1, 1'b1, 1'b0, 1'b0);
        cap_check("uns_7f_80",  20'h7FFFF, 20'h80000, 1'b0, 1'b0, 1'b0, 1'b1);
        cap_check("eq0_u",      20'h00000, 20'h00000, 1'b0, 1'b0, 1'b1, 1'b0);
        cap_check("eq0_s",      20'h00000, 20'h00000, 1'b1, 1'b0, 1'b1, 1'b0);
        cap_check("eqf_u",      20'hFFFFF, 20'hFFFFF, 1'b0, 1'b0, 1'b1, 1'b0);
        cap_check("eqf_s",      20'hFFFFF, 20'hFFFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        cap_check("one_zero_u", 20'h00001, 20'h00000, 1'b0, 1'b1, 1'b0, 1'b0);
        cap_check("one_zero_s", 20'h00001, 20'h00000, 1'b1, 1'b1, 1'b0, 1'b0);

        // Reset overrides a pending capture.
        reset  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);
        expect_lit("reset_prio", 1'b0, 1'b0, 1'b0, 1'b0);
        // Release with cmp_en high: first low edge captures.
        cap_check("post_reset", 20'h00010, 20'h00020, 1'b0, 1'b0, 1'b0, 1'b1);

        // Random back-to-back captures, checked by the model every cycle.
        cmp_en = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            register_A  = WIDTH'($urandom);
            register_B  = (i % 8 == 0) ? register_A : WIDTH'($urandom);
            signed_mode = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        cmp_en = 1'b0;
        repeat (3) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
